garage_rtl: RTL and testbench



---
 rtl/garage_pkg.sv | 25 ++
 rtl/garage_rtl.sv | 79 +++++++
 tb/tb_garage_rtl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/garage_pkg.sv
// Shared definitions for the garage-door motor controller: state encoding,
// illegal-state recovery target and the state-to-motor-command decode.
package garage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MV_UP = 2'b01,
    MV_DN = 2'b10
  } state_e;

  // Any encoding outside the enum falls back here on the next edge.
  localparam state_e RECOVERY_STATE = IDLE;

  // Motor command {up, dn} for a state; at most one bit is ever set.
  function automatic logic [1:0] motor_decode(input state_e st);
    logic [1:0] cmd;
    case (st)
      MV_UP:   cmd = 2'b10;
      MV_DN:   cmd = 2'b01;
      default: cmd = 2'b00;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/garage_rtl.sv
// Garage-door motor controller: three-state Moore FSM driving mutually
// exclusive up/down motor enables from an activate button and limit switches.
module garage_rtl
  import garage_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic Activate,
  input  logic Up_max,
  input  logic Dn_max,
  output logic Up_M,
  output logic Dn_M
);

  state_e     state_r;
  state_e     state_next_s;
  logic [1:0] motor_next_s;
  logic       up_m_r;
  logic       dn_m_r;

  // Next-state logic; limits are only consulted in the direction of travel.
  always_comb begin
    state_next_s = RECOVERY_STATE;
    case (state_r)
      IDLE: begin
        if ((Activate == 1'b1) && !((Up_max == 1'b1) && (Dn_max == 1'b1))) begin
          // Fully open closes; closed or mid-travel opens.
          if (Up_max == 1'b1) begin
            state_next_s = MV_DN;
          end else begin
            state_next_s = MV_UP;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      MV_UP: begin
        if (Up_max == 1'b1) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = MV_UP;
        end
      end
      MV_DN: begin
        if (Dn_max == 1'b1) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = MV_DN;
        end
      end
      default: begin
        state_next_s = RECOVERY_STATE;
      end
    endcase
  end

  // Motor command for the upcoming state, registered below so outputs are flop-driven.
  always_comb begin
    motor_next_s = 2'b00;
    motor_next_s = motor_decode(state_next_s);
  end

  // State and output registers; async reset stops the motor without a clock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      up_m_r  <= 1'b0;
      dn_m_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      up_m_r  <= motor_next_s[1];
      dn_m_r  <= motor_next_s[0];
    end
  end

  assign Up_M = up_m_r;
  assign Dn_M = dn_m_r;

endmodule

// File: tb/tb_garage_rtl.sv
// Self-checking bench for garage_rtl: a behavioural door model pushes expected
// motor outputs into a queue as stimulus is applied; they are popped after the edge.
module tb_garage_rtl;

  logic CLK;
  logic RST;
  logic Activate;
  logic Up_max;
  logic Dn_max;
  logic Up_M;
  logic Dn_M;

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 moving up, 2 moving down
  int         model_st;
  logic [1:0] exp_q[$];

  garage_rtl dut (
    .CLK     (CLK),
    .RST     (RST),
    .Activate(Activate),
    .Up_max  (Up_max),
    .Dn_max  (Dn_max),
    .Up_M    (Up_M),
    .Dn_M    (Dn_M)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_next(input int st, input logic a, input logic u, input logic d);
    if (st == 1) return u ? 0 : 1;
    if (st == 2) return d ? 0 : 2;
    if (!a) return 0;
    if (u && d) return 0;
    if (u) return 2;
    return 1;
  endfunction

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic a, input logic u, input logic d, input string name);
    logic [1:0] exp_v;
    logic [1:0] got;
    Activate = a;
    Up_max   = u;
    Dn_max   = d;
    model_st = model_next(model_st, a, u, d);
    exp_q.push_back({model_st == 1, model_st == 2});
    @(posedge CLK);
    #1;
    exp_v = exp_q.pop_front();
    got   = {Up_M, Dn_M};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: {Up_M,Dn_M} got %b expected %b (in a=%b u=%b d=%b)",
               name, got, exp_v, a, u, d);
    end
  endtask

  task automatic check_off(input string name);
    checks++;
    if ({Up_M, Dn_M} !== 2'b00) begin
      errors++;
      $display("FAIL %s: {Up_M,Dn_M} got %b expected 00", name, {Up_M, Dn_M});
    end
  endtask

  // Release reset with inputs quiet, realigning to posedge+1.
  task automatic release_reset();
    Activate = 1'b0;
    Up_max   = 1'b0;
    Dn_max   = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    model_st = 0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST      = 1'b0;
    Activate = 1'b1;
    Up_max   = 1'b0;
    Dn_max   = 1'b1;
    model_st = 0;
    #1;
    check_off("reset_async_t0");
    repeat (3) @(posedge CLK);
    #1;
    check_off("reset_held_active_inputs");
    release_reset();
    check_off("reset_after_release");
  endtask

  task automatic test_idle_hold();
    repeat (4) step(1'b0, 1'b1, 1'b0, "idle_hold");
  endtask

  task automatic test_open();
    step(1'b1, 1'b0, 1'b1, "open_start");
    step(1'b0, 1'b0, 1'b0, "open_travel");
    step(1'b0, 1'b0, 1'b1, "open_ignore_dn_max");
    step(1'b0, 1'b1, 1'b0, "open_limit_stop");
    step(1'b0, 1'b1, 1'b0, "open_idle_after");
  endtask

  task automatic test_close();
    step(1'b1, 1'b1, 1'b0, "close_start");
    step(1'b1, 1'b0, 1'b0, "close_ignore_activate");
    step(1'b0, 1'b1, 1'b0, "close_ignore_up_max");
    step(1'b0, 1'b0, 1'b1, "close_limit_stop");
  endtask

  task automatic test_no_activate();
    repeat (4) step(1'b0, 1'b0, 1'b1, "no_activate_closed");
  endtask

  task automatic test_fault_and_midrun_reset();
    repeat (3) step(1'b1, 1'b1, 1'b1, "fault_both_limits");
    step(1'b1, 1'b0, 1'b0, "midtravel_opens");
    step(1'b1, 1'b0, 1'b0, "midtravel_moving");
    #2;
    RST = 1'b0;
    model_st = 0;
    #1;
    check_off("midrun_reset_immediate");
    release_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, "after_reset_waits");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b1, "b2b_open");
    step(1'b1, 1'b1, 1'b0, "b2b_open_done");
    step(1'b1, 1'b1, 1'b0, "b2b_retrigger_close");
    step(1'b1, 1'b0, 1'b1, "b2b_close_done");
    step(1'b1, 1'b0, 1'b1, "b2b_retrigger_open");
    step(1'b0, 1'b1, 1'b0, "b2b_final_stop");
  endtask

  task automatic test_random();
    logic [2:0] r;
    for (int i = 0; i < 60; i++) begin
      r = 3'($urandom_range(0, 7));
      step(r[2], r[1], r[0], "random");
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_open();
    test_close();
    test_no_activate();
    test_fault_and_midrun_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
